// File: rtl/mc_defs.sv
// Shared definitions for the multi-cycle MIPS-subset sequencer: FSM states,
// instruction classes, opcode/func encodings, ALU and PC-source codes.
package mc_defs;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    // C_NOP doubles as "undecodable": the top decides whether it traps or retires.
    typedef enum logic [3:0] {
        C_ALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_NOP
    } iclass_t;

    typedef struct packed {
        iclass_t    cls;
        logic [3:0] aluc;
        logic       sext;
        logic       shift;
        logic       regrt;
        logic       alu_src;
    } dec_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;
    localparam logic [3:0] ALUC_LUI = 4'b0110;

    localparam logic [1:0] PCS_PC4  = 2'b00;
    localparam logic [1:0] PCS_BR   = 2'b01;
    localparam logic [1:0] PCS_RS   = 2'b10;
    localparam logic [1:0] PCS_JMP  = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Unified-memory request/acknowledge port shared by instruction fetch and
// data access; the sequencer is the master, the memory the slave.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_sel;
    logic mem_we;
    logic mem_ack;

    modport master (output mem_req, output mem_sel, output mem_we, input mem_ack);
    modport slave  (input mem_req, input mem_sel, input mem_we, output mem_ack);
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction decode: op/func -> class plus the ALU-side
// controls that stay constant from ID to the end of the instruction.
module mc_decode
    import mc_defs::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] func_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o.cls     = C_NOP;
        dec_o.aluc    = ALUC_ADD;
        dec_o.sext    = 1'b0;
        dec_o.shift   = 1'b0;
        dec_o.regrt   = 1'b0;
        dec_o.alu_src = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                case (func_i)
                    FN_ADD: dec_o.cls = C_ALU;
                    FN_SUB: begin dec_o.cls = C_ALU; dec_o.aluc = ALUC_SUB; end
                    FN_AND: begin dec_o.cls = C_ALU; dec_o.aluc = ALUC_AND; end
                    FN_OR:  begin dec_o.cls = C_ALU; dec_o.aluc = ALUC_OR;  end
                    FN_XOR: begin dec_o.cls = C_ALU; dec_o.aluc = ALUC_XOR; end
                    FN_SLL: begin dec_o.cls = C_ALU; dec_o.aluc = ALUC_SLL; dec_o.shift = 1'b1; end
                    FN_SRL: begin dec_o.cls = C_ALU; dec_o.aluc = ALUC_SRL; dec_o.shift = 1'b1; end
                    FN_SRA: begin dec_o.cls = C_ALU; dec_o.aluc = ALUC_SRA; dec_o.shift = 1'b1; end
                    FN_JR:  dec_o.cls = C_JR;
                    default: ;
                endcase
            end
            OP_ADDI: begin
                dec_o.cls = C_ALU; dec_o.sext = 1'b1; dec_o.regrt = 1'b1; dec_o.alu_src = 1'b1;
            end
            // Logical immediates zero-extend.
            OP_ANDI: begin
                dec_o.cls = C_ALU; dec_o.aluc = ALUC_AND; dec_o.regrt = 1'b1; dec_o.alu_src = 1'b1;
            end
            OP_ORI: begin
                dec_o.cls = C_ALU; dec_o.aluc = ALUC_OR; dec_o.regrt = 1'b1; dec_o.alu_src = 1'b1;
            end
            OP_XORI: begin
                dec_o.cls = C_ALU; dec_o.aluc = ALUC_XOR; dec_o.regrt = 1'b1; dec_o.alu_src = 1'b1;
            end
            OP_LUI: begin
                dec_o.cls = C_ALU; dec_o.aluc = ALUC_LUI; dec_o.regrt = 1'b1; dec_o.alu_src = 1'b1;
            end
            OP_LW: begin
                dec_o.cls = C_LW; dec_o.sext = 1'b1; dec_o.regrt = 1'b1; dec_o.alu_src = 1'b1;
            end
            OP_SW: begin
                dec_o.cls = C_SW; dec_o.sext = 1'b1; dec_o.regrt = 1'b1; dec_o.alu_src = 1'b1;
            end
            OP_BEQ: begin
                dec_o.cls = C_BEQ; dec_o.aluc = ALUC_SUB; dec_o.sext = 1'b1; dec_o.regrt = 1'b1;
            end
            OP_BNE: begin
                dec_o.cls = C_BNE; dec_o.aluc = ALUC_SUB; dec_o.sext = 1'b1; dec_o.regrt = 1'b1;
            end
            OP_J:    dec_o.cls = C_J;
            OP_JAL:  dec_o.cls = C_JAL;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer with shared memory handshake and timeout.
// Build option MULTICYCLE_CTRL_ILLEGAL_TRAP_EN: undecodable instructions halt with illegal=1.
module multicycle_ctrl
    import mc_defs::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    input  logic        z,
    multicycle_ctrl_if.master mem,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pcsource,
    output logic        reg_we,
    output logic        regrt,
    output logic        jal,
    output logic        m2reg,
    output logic        alu_src,
    output logic        sext,
    output logic        shift,
    output logic [3:0]  aluc,
    output logic        instr_done,
    output logic        bus_err,
    output logic        illegal
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
    logic             illegal_q, illegal_d;
    logic [5:0]       op_q, func_q;
    logic [5:0]       op_sel, func_sel;
    dec_t             dec;
    logic             req_st;
    logic             timeout;

    // ID decodes the live IR fields; later states use the copy taken in ID.
    assign op_sel   = (state_q == S_ID) ? op   : op_q;
    assign func_sel = (state_q == S_ID) ? func : func_q;

    mc_decode u_decode (
        .op_i   (op_sel),
        .func_i (func_sel),
        .dec_o  (dec)
    );

    assign req_st  = (state_q == S_IF) || (state_q == S_MEM);
    assign timeout = req_st && !mem.mem_ack && (cnt_q == CNT_W'(WAIT_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IF;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
            illegal_q <= illegal_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_ID) begin
            op_q   <= op;
            func_q <= func;
        end
    end

    always_comb begin
        state_d   = state_q;
        bus_err_d = bus_err_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IF: begin
                if (mem.mem_ack) begin
                    state_d = S_ID;
                end else if (timeout) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end
            end
            S_ID: begin
                case (dec.cls)
                    C_J, C_JAL, C_JR: state_d = S_IF;
                    C_NOP: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
`else
                        state_d   = S_IF;
`endif
                    end
                    default: state_d = S_EX;
                endcase
            end
            S_EX: begin
                case (dec.cls)
                    C_BEQ, C_BNE: state_d = S_IF;
                    C_LW, C_SW:   state_d = S_MEM;
                    default:      state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem.mem_ack) begin
                    state_d = (dec.cls == C_SW) ? S_IF : S_WB;
                end else if (timeout) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end
            end
            S_WB:    state_d = S_IF;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // Counter restarts on every ack and on every state change, so each access gets its own budget.
    always_comb begin
        if (!req_st || mem.mem_ack || (state_d != state_q)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        mem.mem_req = 1'b0;
        mem.mem_sel = 1'b0;
        mem.mem_we  = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pcsource    = PCS_PC4;
        reg_we      = 1'b0;
        regrt       = 1'b0;
        jal         = 1'b0;
        m2reg       = 1'b0;
        alu_src     = 1'b0;
        sext        = 1'b0;
        shift       = 1'b0;
        aluc        = ALUC_ADD;
        instr_done  = 1'b0;
        bus_err     = bus_err_q;
        illegal     = illegal_q;
        // Gating with rst_n drops an in-flight request the moment reset asserts.
        if (rst_n && (state_q != S_IF) && (state_q != S_HALT)) begin
            aluc    = dec.aluc;
            sext    = dec.sext;
            shift   = dec.shift;
            regrt   = dec.regrt;
            alu_src = dec.alu_src;
        end
        if (rst_n) begin
            case (state_q)
                S_IF: begin
                    mem.mem_req = 1'b1;
                    if (mem.mem_ack) begin
                        ir_we = 1'b1;
                        pc_we = 1'b1;
                    end
                end
                S_ID: begin
                    case (dec.cls)
                        C_J: begin
                            pc_we = 1'b1; pcsource = PCS_JMP; instr_done = 1'b1;
                        end
                        C_JAL: begin
                            pc_we = 1'b1; pcsource = PCS_JMP; instr_done = 1'b1;
                            reg_we = 1'b1; jal = 1'b1;
                        end
                        C_JR: begin
                            pc_we = 1'b1; pcsource = PCS_RS; instr_done = 1'b1;
                        end
`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                        C_NOP: instr_done = 1'b1;
`endif
                        default: ;
                    endcase
                end
                S_EX: begin
                    if (dec.cls == C_BEQ || dec.cls == C_BNE) begin
                        pc_we      = (dec.cls == C_BEQ) ? z : ~z;
                        pcsource   = PCS_BR;
                        instr_done = 1'b1;
                    end
                end
                S_MEM: begin
                    mem.mem_req = 1'b1;
                    mem.mem_sel = 1'b1;
                    mem.mem_we  = (dec.cls == C_SW);
                    instr_done  = mem.mem_ack && (dec.cls == C_SW);
                end
                S_WB: begin
                    reg_we     = 1'b1;
                    m2reg      = (dec.cls == C_LW);
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: per-instruction expected
// control traces are built from an instruction table and the stage rules.
module tb_multicycle_ctrl;

    localparam int WAIT_MAX = 15;
    localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_BNE = 4;
    localparam int K_J = 5, K_JAL = 6, K_JR = 7, K_ILL = 8;
    localparam logic [20:0] M_ALL   = 21'h1FFFFF;
    localparam logic [20:0] M_NODEC = 21'h1FFF00;

    typedef struct packed {
        logic       illegal, bus_err, mem_req, mem_sel, mem_we, ir_we, pc_we;
        logic [1:0] pcsource;
        logic       reg_we, jal, m2reg, done, regrt, alu_src, sext, shift;
        logic [3:0] aluc;
    } ctl_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] func;
        int         kind;
        logic [3:0] aluc;
        logic       sext, shift, regrt, alu_src;
    } ins_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op, func;
    logic       z;
    logic       ir_we, pc_we, reg_we, regrt, jal, m2reg, alu_src, sext, shift;
    logic       instr_done, bus_err, illegal;
    logic [1:0] pcsource;
    logic [3:0] aluc;
    int         n_chk = 0;
    int         n_err = 0;
    ins_t       tbl[$];

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .func(func), .z(z), .mem(bus),
        .ir_we(ir_we), .pc_we(pc_we), .pcsource(pcsource), .reg_we(reg_we),
        .regrt(regrt), .jal(jal), .m2reg(m2reg), .alu_src(alu_src), .sext(sext),
        .shift(shift), .aluc(aluc), .instr_done(instr_done), .bus_err(bus_err),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic ctl_t obs();
        ctl_t o;
        o = {illegal, bus_err, bus.mem_req, bus.mem_sel, bus.mem_we, ir_we, pc_we,
             pcsource, reg_we, jal, m2reg, instr_done, regrt, alu_src, sext, shift, aluc};
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic add_ins(input string nm, input logic [5:0] o, input logic [5:0] f, input int k,
                           input logic [3:0] ac, input logic se, input logic sh,
                           input logic rt, input logic as);
        ins_t i;
        i.name = nm; i.op = o; i.func = f; i.kind = k; i.aluc = ac;
        i.sext = se; i.shift = sh; i.regrt = rt; i.alu_src = as;
        tbl.push_back(i);
    endtask

    function automatic ins_t find(input string nm);
        foreach (tbl[i]) if (tbl[i].name == nm) return tbl[i];
        return tbl[0];
    endfunction

    function automatic int lat(input int k);
        case (k)
            K_J, K_JAL, K_JR, K_ILL: return 2;
            K_BEQ, K_BNE:            return 3;
            K_LW:                    return 5;
            default:                 return 4;
        endcase
    endfunction

    task automatic drv(input logic ack);
        bus.mem_ack = ack;
        z = 1'($urandom);
    endtask

    task automatic cyc(input ctl_t e, input logic [20:0] m, input string tag);
        @(negedge clk);
        chk(tag, {11'd0, obs() & m}, {11'd0, e & m});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        chk("rst", {11'd0, obs()}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // zsel < 0 leaves the EX-cycle zero flag random.
    task automatic run_instr(input ins_t ins, input int wif, input int wmem, input int zsel);
        ctl_t d, e;
        int   cycles;
        cycles = 0;
        d = '0;
        d.aluc = ins.aluc; d.sext = ins.sext; d.shift = ins.shift;
        d.regrt = ins.regrt; d.alu_src = ins.alu_src;

        for (int i = 0; i <= wif; i++) begin
            drv(i == wif);
            op = 6'($urandom); func = 6'($urandom);
            e = '0; e.mem_req = 1'b1;
            if (i == wif) begin e.ir_we = 1'b1; e.pc_we = 1'b1; end
            cyc(e, M_NODEC, {"if_", ins.name});
            cycles++;
        end
        op = ins.op; func = ins.func;

        drv(1'($urandom));
        e = d;
        case (ins.kind)
            K_J:   begin e.pc_we = 1'b1; e.pcsource = 2'b11; e.done = 1'b1; end
            K_JAL: begin e.pc_we = 1'b1; e.pcsource = 2'b11; e.done = 1'b1; e.reg_we = 1'b1; e.jal = 1'b1; end
            K_JR:  begin e.pc_we = 1'b1; e.pcsource = 2'b10; e.done = 1'b1; end
`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            K_ILL: e.done = 1'b1;
`endif
            default: ;
        endcase
        cyc(e, (ins.kind == K_ILL) ? M_NODEC : M_ALL, {"id_", ins.name});
        cycles++;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        if (ins.kind == K_ILL) begin
            for (int i = 0; i < 3; i++) begin
                drv(1'($urandom));
                e = '0; e.illegal = 1'b1;
                cyc(e, M_ALL, "ill_halt");
            end
            do_reset();
            return;
        end
`endif
        if (ins.kind inside {K_ALU, K_LW, K_SW, K_BEQ, K_BNE}) begin
            drv(1'($urandom));
            if (zsel >= 0) z = 1'(zsel);
            e = d;
            if (ins.kind == K_BEQ || ins.kind == K_BNE) begin
                e.pc_we = (ins.kind == K_BEQ) ? z : !z;
                e.pcsource = 2'b01;
                e.done = 1'b1;
            end
            cyc(e, M_ALL, {"ex_", ins.name});
            cycles++;
        end
        if (ins.kind == K_LW || ins.kind == K_SW) begin
            for (int i = 0; i <= wmem; i++) begin
                drv(i == wmem);
                e = d; e.mem_req = 1'b1; e.mem_sel = 1'b1; e.mem_we = (ins.kind == K_SW);
                if (i == wmem && ins.kind == K_SW) e.done = 1'b1;
                cyc(e, M_ALL, {"mem_", ins.name});
                cycles++;
            end
        end
        if (ins.kind == K_ALU || ins.kind == K_LW) begin
            drv(1'($urandom));
            e = d; e.reg_we = 1'b1; e.m2reg = (ins.kind == K_LW); e.done = 1'b1;
            cyc(e, M_ALL, {"wb_", ins.name});
            cycles++;
        end
        chk({"lat_", ins.name}, 32'(cycles),
            32'(lat(ins.kind) + wif + ((ins.kind == K_LW || ins.kind == K_SW) ? wmem : 0)));
    endtask

    task automatic bus_timeout();
        ctl_t e;
        for (int i = 0; i < WAIT_MAX; i++) begin
            drv(1'b0);
            op = 6'($urandom); func = 6'($urandom);
            e = '0; e.mem_req = 1'b1;
            cyc(e, M_NODEC, "to_wait");
        end
        for (int i = 0; i < 3; i++) begin
            drv(1'($urandom));
            e = '0; e.bus_err = 1'b1;
            cyc(e, M_ALL, "to_halt");
        end
        do_reset();
    endtask

    initial begin
        ins_t pick;
        int   wi, wm;
        rst_n = 1'b0; bus.mem_ack = 1'b1; op = '0; func = '0; z = 1'b0;
        add_ins("add",  6'b000000, 6'b100000, K_ALU, 4'b0000, 0, 0, 0, 0);
        add_ins("sub",  6'b000000, 6'b100010, K_ALU, 4'b0100, 0, 0, 0, 0);
        add_ins("and",  6'b000000, 6'b100100, K_ALU, 4'b0001, 0, 0, 0, 0);
        add_ins("or",   6'b000000, 6'b100101, K_ALU, 4'b0101, 0, 0, 0, 0);
        add_ins("xor",  6'b000000, 6'b100110, K_ALU, 4'b0010, 0, 0, 0, 0);
        add_ins("sll",  6'b000000, 6'b000000, K_ALU, 4'b0011, 0, 1, 0, 0);
        add_ins("srl",  6'b000000, 6'b000010, K_ALU, 4'b0111, 0, 1, 0, 0);
        add_ins("sra",  6'b000000, 6'b000011, K_ALU, 4'b1111, 0, 1, 0, 0);
        add_ins("jr",   6'b000000, 6'b001000, K_JR,  4'b0000, 0, 0, 0, 0);
        add_ins("addi", 6'b001000, 6'b010101, K_ALU, 4'b0000, 1, 0, 1, 1);
        add_ins("andi", 6'b001100, 6'b111000, K_ALU, 4'b0001, 0, 0, 1, 1);
        add_ins("ori",  6'b001101, 6'b000111, K_ALU, 4'b0101, 0, 0, 1, 1);
        add_ins("xori", 6'b001110, 6'b101010, K_ALU, 4'b0010, 0, 0, 1, 1);
        add_ins("lui",  6'b001111, 6'b110011, K_ALU, 4'b0110, 0, 0, 1, 1);
        add_ins("lw",   6'b100011, 6'b001100, K_LW,  4'b0000, 1, 0, 1, 1);
        add_ins("sw",   6'b101011, 6'b100001, K_SW,  4'b0000, 1, 0, 1, 1);
        add_ins("beq",  6'b000100, 6'b011110, K_BEQ, 4'b0100, 1, 0, 1, 0);
        add_ins("bne",  6'b000101, 6'b000001, K_BNE, 4'b0100, 1, 0, 1, 0);
        add_ins("j",    6'b000010, 6'b100000, K_J,   4'b0000, 0, 0, 0, 0);
        add_ins("jal",  6'b000011, 6'b100010, K_JAL, 4'b0000, 0, 0, 0, 0);
        add_ins("illop", 6'b111111, 6'b000000, K_ILL, 4'b0000, 0, 0, 0, 0);
        add_ins("illfn", 6'b000000, 6'b111111, K_ILL, 4'b0000, 0, 0, 0, 0);

        @(posedge clk);
        #1;
        do_reset();

        run_instr(find("add"), 0, 0, -1);
        run_instr(find("lw"), 1, 1, -1);
        run_instr(find("beq"), 0, 0, 1);
        run_instr(find("beq"), 0, 0, 0);
        run_instr(find("bne"), 0, 0, 1);
        run_instr(find("bne"), 0, 0, 0);
        run_instr(find("jal"), 0, 0, -1);
        run_instr(find("sw"), WAIT_MAX - 1, WAIT_MAX - 1, -1);
        run_instr(find("illop"), 0, 0, -1);
        run_instr(find("add"), 0, 0, -1);

        for (int n = 0; n < 150; n++) begin
            pick = tbl[$urandom_range(0, tbl.size() - 1)];
            wi = ($urandom_range(0, 9) == 0) ? WAIT_MAX - 1 : $urandom_range(0, 3);
            wm = ($urandom_range(0, 9) == 0) ? WAIT_MAX - 1 : $urandom_range(0, 3);
            run_instr(pick, wi, wm, -1);
        end

        bus_timeout();
        run_instr(find("ori"), 0, 0, -1);

        // Reset while a fetch is waiting must drop the request.
        drv(1'b0);
        cyc(ctl_t'(21'h040000), M_NODEC, "pre_rst_req");
        do_reset();
        run_instr(find("lw"), 2, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
